// File: rtl/vga_pkg.sv
// Shared VGA timing, text-mode geometry and VRAM arbiter state encoding.
// State set grows by RD_CPU when VRAM_ARB_READBACK_EN is defined.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int TEXT_COLS  = 80;
  localparam int TEXT_ROWS  = 30;
  localparam int VRAM_AW    = 12;
  localparam int VRAM_DEPTH = 2400;

  localparam logic [VRAM_AW-1:0] VRAM_LIMIT = VRAM_AW'(VRAM_DEPTH);

`ifdef VRAM_ARB_READBACK_EN
  typedef enum logic [2:0] {IDLE, DISP_RD, DISP_CAP, WR, RD_CPU} arb_state_t;
`else
  typedef enum logic [1:0] {IDLE, DISP_RD, DISP_CAP, WR} arb_state_t;
`endif

  // row*80 + col as shift-add; row <= 29 and col <= 79 keep the sum below 2400.
  function automatic logic [VRAM_AW-1:0] text_addr(input logic [4:0] row,
                                                   input logic [6:0] col);
    logic [VRAM_AW-1:0] r;
    r = {7'd0, row};
    return (r << 6) + (r << 4) + {5'd0, col};
  endfunction

endpackage

// File: rtl/tick_edge_det.sv
// Rising-edge detector for the pixel-rate enable; the pulse is high in the
// first CLK of each p_tick high phase.
module tick_edge_det
  import vga_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  input  logic p_tick,
  output logic tick_rise
);

  logic p_tick_d_reg;

  always_ff @(posedge CLK) begin
    if (RESET) p_tick_d_reg <= 1'b0;
    else       p_tick_d_reg <= p_tick;
  end

  assign tick_rise = p_tick & ~p_tick_d_reg;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display character fetch has absolute priority over
// RTC writes. Define VRAM_ARB_READBACK_EN to add a CPU read-back port (RD_CPU).
module vram_arbiter
  import vga_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                p_tick,
  input  logic [9:0]          pixel_X,
  input  logic [9:0]          pixel_Y,
  input  logic                wr_req,
  input  logic [VRAM_AW-1:0]  wr_addr,
  input  logic [7:0]          wr_data,
  output logic                wr_ack,
  output logic                wr_err,
`ifdef VRAM_ARB_READBACK_EN
  input  logic                rd_req,
  input  logic [VRAM_AW-1:0]  rd_addr,
  output logic [7:0]          rd_data,
  output logic                rd_ack,
`endif
  output logic [VRAM_AW-1:0]  ram_addr,
  output logic                ram_we,
  output logic [7:0]          ram_wdata,
  input  logic [7:0]          ram_rdata,
  output logic [7:0]          char_code,
  output logic                char_valid
);

  arb_state_t         state_reg;
  logic [VRAM_AW-1:0] ram_addr_reg;
  logic               ram_we_reg;
  logic [7:0]         ram_wdata_reg;
  logic [7:0]         char_code_reg;
  logic               char_valid_reg;
  logic               wr_ack_reg;
  logic               wr_err_reg;

  logic               tick_rise;
  logic               fetch_slot;
  logic [VRAM_AW-1:0] disp_addr;
  logic               wr_bad;
  logic               grant_wr;

  tick_edge_det u_tick_edge_det (
    .CLK       (CLK),
    .RESET     (RESET),
    .p_tick    (p_tick),
    .tick_rise (tick_rise)
  );

  assign fetch_slot = tick_rise
                    && (pixel_X < 10'(H_VISIBLE))
                    && (pixel_Y < 10'(V_VISIBLE))
                    && (pixel_X[2:0] == 3'd0);
  assign disp_addr  = text_addr(pixel_Y[8:4], pixel_X[9:3]);
  assign wr_bad     = (wr_addr >= VRAM_LIMIT);

`ifdef VRAM_ARB_READBACK_EN
  logic       rd_cap_reg;
  logic       rd_bad_reg;
  logic       rd_ack_reg;
  logic [7:0] rd_data_reg;
  logic       last_rd_reg;
  logic       rd_ok;
  logic       grant_rd;

  // A request still held during its own capture/ack cycle is not a new one.
  assign rd_ok    = rd_req && !rd_cap_reg && !rd_ack_reg;
  assign grant_wr = wr_req && (!rd_ok || last_rd_reg);
  assign grant_rd = rd_ok && !grant_wr;
  assign rd_ack   = rd_ack_reg;
  assign rd_data  = rd_data_reg;
`else
  assign grant_wr = wr_req;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg      <= IDLE;
      ram_addr_reg   <= '0;
      ram_we_reg     <= 1'b0;
      ram_wdata_reg  <= 8'h00;
      char_code_reg  <= 8'h00;
      char_valid_reg <= 1'b0;
      wr_ack_reg     <= 1'b0;
      wr_err_reg     <= 1'b0;
`ifdef VRAM_ARB_READBACK_EN
      rd_cap_reg     <= 1'b0;
      rd_bad_reg     <= 1'b0;
      rd_ack_reg     <= 1'b0;
      rd_data_reg    <= 8'h00;
      last_rd_reg    <= 1'b0;
`endif
    end else begin
      ram_we_reg     <= 1'b0;
      char_valid_reg <= 1'b0;
      wr_ack_reg     <= 1'b0;
      wr_err_reg     <= 1'b0;
`ifdef VRAM_ARB_READBACK_EN
      rd_ack_reg     <= 1'b0;
      rd_cap_reg     <= 1'b0;
      // Read data arrives the cycle after RD_CPU, whatever the FSM does next.
      if (rd_cap_reg) begin
        rd_data_reg <= rd_bad_reg ? 8'h00 : ram_rdata;
        rd_ack_reg  <= 1'b1;
      end
`endif
      case (state_reg)
        IDLE: begin
          if (fetch_slot) begin
            state_reg    <= DISP_RD;
            ram_addr_reg <= disp_addr;
          end else if (grant_wr) begin
            state_reg     <= WR;
            ram_addr_reg  <= wr_addr;
            ram_wdata_reg <= wr_data;
            ram_we_reg    <= !wr_bad;
            wr_ack_reg    <= 1'b1;
            wr_err_reg    <= wr_bad;
`ifdef VRAM_ARB_READBACK_EN
            last_rd_reg   <= 1'b0;
          end else if (grant_rd) begin
            state_reg     <= RD_CPU;
            ram_addr_reg  <= rd_addr;
            rd_bad_reg    <= (rd_addr >= VRAM_LIMIT);
            last_rd_reg   <= 1'b1;
`endif
          end
        end
        DISP_RD:  state_reg <= DISP_CAP;
        DISP_CAP: begin
          char_code_reg  <= ram_rdata;
          char_valid_reg <= 1'b1;
          state_reg      <= IDLE;
        end
        WR:       state_reg <= IDLE;
`ifdef VRAM_ARB_READBACK_EN
        RD_CPU: begin
          rd_cap_reg <= 1'b1;
          state_reg  <= IDLE;
        end
`endif
        default:  state_reg <= IDLE;
      endcase
    end
  end

  assign ram_addr   = ram_addr_reg;
  assign ram_we     = ram_we_reg;
  assign ram_wdata  = ram_wdata_reg;
  assign char_code  = char_code_reg;
  assign char_valid = char_valid_reg;
  assign wr_ack     = wr_ack_reg;
  assign wr_err     = wr_err_reg;

endmodule
